// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge filter: two line buffers, a 2-column window register,
// a Gx/Gy stage and an output stage (magnitude or thresholded binary).
module sobel_stream_filter #(
  parameter int IMG_W    = 100,
  parameter int IMG_H    = 100,
  parameter int DATA_W   = 8,
  parameter int THR_INIT = 80,
  parameter int THR_STEP = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              frame_sync,
  input  logic              key_inc,
  input  logic              key_dec,
  input  logic              mode_bin,
  output logic [DATA_W-1:0] threshold,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              frame_done
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int GW = DATA_W + 3;
  localparam logic [CW-1:0]     COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]     ROW_LAST = RW'(IMG_H - 1);
  localparam logic [DATA_W-1:0] PIX_MAX  = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] THR_RST  = DATA_W'(THR_INIT);
  localparam logic [DATA_W:0]   STEP_W   = (DATA_W + 1)'(THR_STEP);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          accept, interior, last_px;

  logic [DATA_W-1:0] lb1_mem [IMG_W];
  logic [DATA_W-1:0] lb2_mem [IMG_W];
  logic [DATA_W-1:0] top_px, mid_px;
  logic [DATA_W-1:0] win_a_q [3];
  logic [DATA_W-1:0] win_b_q [3];
  logic [DATA_W-1:0] win_new [3];

  logic [GW-1:0]        left_sum, right_sum, top_sum, bot_sum;
  logic signed [GW-1:0] gx_d, gy_d, gx_q, gy_q;
  logic                 s1_valid_d, s1_valid_q, s1_last_d, s1_last_q;
  logic [GW-1:0]        abs_gx, abs_gy, mag;
  logic                 out_valid_d, out_valid_q, frame_done_d, frame_done_q;
  logic [DATA_W-1:0]    out_data_d, out_data_q;
  logic [DATA_W-1:0]    threshold_d, threshold_q;
  logic [DATA_W:0]      thr_inc, thr_dec;

  function automatic logic [GW-1:0] wsum(input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b,
                                         input logic [DATA_W-1:0] c);
    return GW'(a) + (GW'(b) << 1) + GW'(c);
  endfunction

  // frame_sync wins over a same-cycle in_valid, which is dropped
  assign accept   = in_valid && !frame_sync;
  assign interior = (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign last_px  = (row_q == ROW_LAST) && (col_q == COL_LAST);

  assign mid_px     = lb1_mem[col_q];
  assign top_px     = lb2_mem[col_q];
  assign win_new[0] = top_px;
  assign win_new[1] = mid_px;
  assign win_new[2] = in_data;

  always_ff @(posedge sys_clk) begin
    if (accept) begin
      lb1_mem[col_q] <= in_data;
      lb2_mem[col_q] <= mid_px;
    end
  end

  // The window holds columns c-2 and c-1; column c comes straight from the buffers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < 3; i++) begin
        win_a_q[i] <= '0;
        win_b_q[i] <= '0;
      end
    end else if (frame_sync) begin
      for (int i = 0; i < 3; i++) begin
        win_a_q[i] <= '0;
        win_b_q[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < 3; i++) begin
        win_a_q[i] <= win_b_q[i];
        win_b_q[i] <= win_new[i];
      end
    end
  end

  assign left_sum  = wsum(win_a_q[0], win_a_q[1], win_a_q[2]);
  assign right_sum = wsum(top_px, mid_px, in_data);
  assign top_sum   = wsum(win_a_q[0], win_b_q[0], top_px);
  assign bot_sum   = wsum(win_a_q[2], win_b_q[2], in_data);
  // Both sums stay below 2^(DATA_W+2), so the wrapped difference is exact two's complement
  assign gx_d = $signed(right_sum - left_sum);
  assign gy_d = $signed(bot_sum - top_sum);

  assign abs_gx = gx_q[GW-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
  assign abs_gy = gy_q[GW-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
  assign mag    = abs_gx + abs_gy;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (frame_sync) begin
      col_d = '0;
      row_d = '0;
    end else if (in_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    s1_valid_d = accept && interior;
    s1_last_d  = accept && last_px;

    out_valid_d  = s1_valid_q && !frame_sync;
    frame_done_d = out_valid_d && s1_last_q;
    out_data_d   = out_data_q;
    if (s1_valid_q) begin
      if (mode_bin)
        out_data_d = (mag >= {3'b000, threshold_q}) ? PIX_MAX : '0;
      else if (|mag[GW-1:DATA_W])
        out_data_d = PIX_MAX;
      else
        out_data_d = mag[DATA_W-1:0];
    end

    thr_inc     = {1'b0, threshold_q} + STEP_W;
    thr_dec     = {1'b0, threshold_q} - STEP_W;
    threshold_d = threshold_q;
    if (key_inc && !key_dec)
      threshold_d = (thr_inc > {1'b0, PIX_MAX}) ? PIX_MAX : thr_inc[DATA_W-1:0];
    else if (key_dec && !key_inc)
      threshold_d = ({1'b0, threshold_q} < STEP_W) ? '0 : thr_dec[DATA_W-1:0];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      gx_q         <= '0;
      gy_q         <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
      threshold_q  <= THR_RST;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      s1_valid_q   <= s1_valid_d;
      s1_last_q    <= s1_last_d;
      if (s1_valid_d) begin
        gx_q <= gx_d;
        gy_q <= gy_d;
      end
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
      threshold_q  <= threshold_d;
    end
  end

  assign threshold  = threshold_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_sobel_stream_filter.sv
// Bench for sobel_stream_filter: an image-array reference model checked every cycle,
// plus literal expectations per scenario.
module tb_sobel_stream_filter;
  localparam int W = 8, H = 6, DW = 8, TI = 80, TS = 4, PMAX = 255;

  logic          sys_clk = 1'b0, sys_rst_n = 1'b0;
  logic          in_valid = 1'b0, frame_sync = 1'b0;
  logic          key_inc = 1'b0, key_dec = 1'b0, mode_bin = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] threshold, out_data;
  logic          out_valid, frame_done;

  always #5 sys_clk = ~sys_clk;

  sobel_stream_filter #(.IMG_W(W), .IMG_H(H), .DATA_W(DW), .THR_INIT(TI), .THR_STEP(TS)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_valid(in_valid), .in_data(in_data),
    .frame_sync(frame_sync), .key_inc(key_inc), .key_dec(key_dec), .mode_bin(mode_bin),
    .threshold(threshold), .out_valid(out_valid), .out_data(out_data), .frame_done(frame_done)
  );

  int n_vec = 0, n_err = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference model: frame image, raster position, threshold and outputs due per edge
  typedef struct { int due; int mag; bit last; } pend_t;
  int    img [H][W];
  int    m_row = 0, m_col = 0, m_thr = TI, cyc = 0;
  pend_t pend [$];
  pend_t p;
  bit    exp_valid = 0, exp_last = 0;
  int    exp_data = 0;

  function automatic int sobel_mag(input int r, input int c);
    int gx, gy;
    gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
       - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
    gy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
       - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
    return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
  endfunction

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pend.delete();
      m_row = 0; m_col = 0; m_thr = TI;
      exp_valid = 0; exp_last = 0; exp_data = 0;
    end else begin
      cyc++;
      exp_valid = 0;
      exp_last  = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        p = pend.pop_front();
        if (!frame_sync) begin
          exp_valid = 1;
          exp_last  = p.last;
          if (mode_bin) exp_data = (p.mag >= m_thr) ? PMAX : 0;
          else          exp_data = (p.mag > PMAX) ? PMAX : p.mag;
        end
      end
      if (frame_sync) begin
        pend.delete();
        m_row = 0; m_col = 0;
      end else if (in_valid) begin
        img[m_row][m_col] = int'(in_data);
        if (m_row >= 2 && m_col >= 2)
          pend.push_back('{cyc + 1, sobel_mag(m_row - 1, m_col - 1), (m_row == H-1 && m_col == W-1)});
        if (m_col == W-1) begin
          m_col = 0;
          m_row = (m_row == H-1) ? 0 : m_row + 1;
        end else m_col++;
      end
      if (key_inc && !key_dec)      m_thr = (m_thr + TS > PMAX) ? PMAX : m_thr + TS;
      else if (key_dec && !key_inc) m_thr = (m_thr - TS < 0) ? 0 : m_thr - TS;
    end
  end

  always @(negedge sys_clk) begin
    if (cmp_en) begin
      chk("out_valid", out_valid, exp_valid);
      chk("frame_done", frame_done, exp_valid && exp_last);
      if (exp_valid) chk("out_data", out_data, exp_data);
      chk("threshold", threshold, m_thr);
    end
  end

  // Observed-output statistics for the literal checks
  int cap [$];
  int out_cyc [$];
  int acc_cyc [$];
  int fd_cnt = 0, fd_cyc = -1;

  always @(negedge sys_clk) begin
    if (out_valid) begin
      cap.push_back(int'(out_data));
      out_cyc.push_back(cyc);
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (sys_rst_n && in_valid && !frame_sync) acc_cyc.push_back(cyc);
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 0; frame_sync = 0; key_inc = 0; key_dec = 0;
    repeat (n) tick();
  endtask

  task automatic clear_stats();
    cap.delete(); out_cyc.delete(); acc_cyc.delete();
    fd_cnt = 0; fd_cyc = -1;
  endtask

  // kind 0: flat 100; 1: step 0|255 at col 4; 2: ramp col*5 (|Gx| = 4*10 = 40)
  function automatic int pix(input int kind, input int c);
    case (kind)
      0:       return 100;
      1:       return (c < 4) ? 0 : 255;
      default: return c * 5;
    endcase
  endfunction

  task automatic send_frame(input int kind, input int duty, input int npix);
    int k = 0;
    while (k < npix) begin
      if (duty >= 100 || $urandom_range(0, 99) < duty) begin
        in_valid = 1; in_data = DW'(pix(kind, k % W)); k++;
      end else in_valid = 0;
      tick();
    end
    in_valid = 0;
    idle(4);
  endtask

  task automatic press(input bit inc, input bit dec, input int n);
    repeat (n) begin
      key_inc = inc; key_dec = dec;
      tick();
    end
    key_inc = 0; key_dec = 0;
    tick();
  endtask

  task automatic check_step(input string name, input int frames);
    int e;
    chk({name, "_count"}, cap.size(), 24 * frames);
    chk({name, "_frame_done"}, fd_cnt, frames);
    foreach (cap[i]) begin
      e = ((i % 6) + 1 == 3 || (i % 6) + 1 == 4) ? 255 : 0;
      chk($sformatf("%s_px%0d", name, i), cap[i], e);
    end
  endtask

  task automatic check_all(input string name, input int val);
    chk({name, "_count"}, cap.size(), 24);
    chk({name, "_frame_done"}, fd_cnt, 1);
    foreach (cap[i]) chk($sformatf("%s_px%0d", name, i), cap[i], val);
  endtask

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    repeat (2) tick();
    cmp_en = 1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_threshold", threshold, 80);
    sys_rst_n = 1;
    idle(2);

    // 1: flat frame, latency and frame_done alignment
    clear_stats();
    send_frame(0, 100, 48);
    check_all("flat", 0);
    if (out_cyc.size() == 24 && acc_cyc.size() == 48) begin
      chk("lat_first", out_cyc[0] - acc_cyc[18], 2);
      chk("lat_last", out_cyc[23] - acc_cyc[47], 2);
      chk("fd_with_last", fd_cyc, out_cyc[23]);
    end else chk("lat_counts", out_cyc.size() * 100 + acc_cyc.size(), 24 * 100 + 48);

    // 2: vertical step, magnitude
    clear_stats();
    send_frame(1, 100, 48);
    chk("model_step_mag", sobel_mag(2, 3), 1020);
    check_step("step_mag", 1);

    // 3: binary mode, threshold walk over a ramp
    mode_bin = 1;
    clear_stats();
    send_frame(1, 100, 48);
    check_step("step_bin", 1);
    press(0, 1, 5);
    chk("thr_after_5dec", threshold, 60);
    clear_stats();
    send_frame(2, 100, 48);
    chk("model_ramp_mag", sobel_mag(2, 3), 40);
    check_all("ramp_thr60", 0);
    press(1, 0, 5);
    chk("thr_after_5inc", threshold, 80);
    clear_stats();
    send_frame(2, 100, 48);
    check_all("ramp_thr80", 0);
    press(0, 1, 10);
    chk("thr_40", threshold, 40);
    clear_stats();
    send_frame(2, 100, 48);
    check_all("ramp_thr40", 255);

    // 4: threshold saturation and simultaneous keys
    press(1, 0, 60);
    chk("thr_sat_hi", threshold, 255);
    press(0, 1, 70);
    chk("thr_sat_lo", threshold, 0);
    press(1, 0, 3);
    chk("thr_12", threshold, 12);
    press(1, 1, 5);
    chk("thr_both", threshold, 12);

    // 5: frame_sync abort (with a dropped same-cycle pixel), then mid-frame reset
    mode_bin = 0;
    send_frame(1, 100, 20);
    frame_sync = 1; in_valid = 1; in_data = 8'd255;
    tick();
    frame_sync = 0; in_valid = 0;
    clear_stats();
    send_frame(1, 100, 48);
    check_step("after_sync", 1);

    in_valid = 1;
    for (int k = 0; k < 30; k++) begin
      in_data = DW'(pix(1, k % W));
      tick();
    end
    in_valid = 0;
    sys_rst_n = 0;
    tick();
    tick();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_threshold", threshold, 80);
    sys_rst_n = 1;
    idle(2);
    clear_stats();
    send_frame(0, 100, 48);
    check_all("after_rst", 0);

    // 6: two back-to-back step frames with sparse in_valid
    clear_stats();
    send_frame(1, 30, 96);
    check_step("gapped", 2);

    cmp_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
